adc_multich_recorder: RTL
=========================

# adc_multich_recorder

Parametrised multi-channel successor to the single-channel ADC recorder. It sequences ADC conversions round-robin across an enabled-channel mask and issues one conversion trigger per sample. It produces a block-RAM write strobe, address and channel tag for each completed conversion. It sits between the SPI config registers/push button and the ADC + BRAM, and supports single-shot fill and continuous ring capture with abort.

## Interface
- ADDR_BITS, 16, BRAM address width
- NUM_CH, 4, ADC channel count (1..16)
- CH_BITS, $clog2(NUM_CH) (min 1), channel index width

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- cfg_start  in  1  self-clearing one-cycle start pulse from config
- btn_start  in  1  synchronised push-button level; rising edge = start
- cfg_abort  in  1  one-cycle abort pulse
- cfg_mode  in  1  0 = single-shot fill, 1 = continuous ring
- cfg_ch_mask  in  NUM_CH  enabled channels, sampled at start
- cfg_depth  in  ADDR_BITS  last address written (capture length = cfg_depth+1)
- adc_eoc_out  in  1  ADC end-of-conversion level
- adc_trigger  out  1  one-cycle conversion request
- adc_channel  out  CH_BITS  channel of pending conversion
- adc_addr  out  ADDR_BITS  BRAM write address
- adc_write_enable  out  1  BRAM write strobe
- busy  out  1  high in CONVERT
- done  out  1  single-shot complete, held until next start
- wrapped  out  1  ring has overwritten address 0 at least once since start

## Operation
- Start event (start_evt) = cfg_start OR rising edge of btn_start (edge detector register reset 0).
- eoc_rise = adc_eoc_out AND NOT eoc_d; eoc_d is a registered copy, reset 0.
- FSM has three states: IDLE (reset), CONVERT, DONE.
- IDLE/DONE + start_evt + cfg_ch_mask != 0 -> CONVERT. Load mask_q, addr = 0, adc_channel = lowest set bit, clear done/wrapped, and pulse adc_trigger on the next cycle.
- start_evt with mask == 0 is ignored; state is unchanged.
- start_evt in CONVERT is ignored.
- In CONVERT, each eoc_rise asserts adc_write_enable combinationally in that cycle, using the current adc_addr/adc_channel.
- On the following edge after eoc_rise:
  - adc_channel advances to the next set bit of mask_q above the current one, wrapping to the lowest set bit. A single-bit mask stays on its channel.
  - If adc_addr != cfg_depth: addr+1 and adc_trigger pulses.
  - If adc_addr == cfg_depth in mode 0: go to DONE, done = 1, no trigger.
  - If adc_addr == cfg_depth in mode 1: addr = 0, wrapped = 1, trigger pulses.
- eoc_rise outside CONVERT is ignored: no write, no trigger.
- cfg_abort in CONVERT -> IDLE next cycle. Abort beats a same-cycle eoc_rise: adc_write_enable is gated low, no trigger. adc_addr and wrapped hold; done stays 0.
- cfg_depth is read live. Changing it mid-capture to below the current addr makes the capture run until addr wraps at 2^ADDR_BITS.
- cfg_mode is sampled at start.

## Timing
- Reset values: adc_trigger 0, adc_channel 0, adc_addr 0, adc_write_enable 0, busy 0, done 0, wrapped 0.
- Start at cycle S -> busy and adc_trigger high at S+1 (trigger width exactly 1).
- eoc_rise at cycle E -> write at E; addr/channel update and next trigger at E+1.
- Minimum per-sample overhead is 1 clk beyond ADC conversion time.
- A btn_start held high produces one start only.
- Reset mid-operation returns all outputs to reset values immediately.

## Configuration
- ADC_RECORDER_DECIM_EN defined: adds input cfg_decim[7:0], sampled at start.
  - Triggers are still issued every conversion.
  - Only every (cfg_decim+1)-th eoc_rise (counting from the first after start) asserts adc_write_enable and advances addr/channel.
  - A decimation counter resets at start.
  - cfg_decim = 0 behaves identically to the macro-undefined build.
- Undefined: no cfg_decim port; every eoc_rise in CONVERT is written.

## Test plan
- Mask 4'b1011, depth 5, mode 0, cfg_start; ADC eoc 10 clk after each trigger -> writes at addr 0..5 with channels 0,1,3,0,1,3; done=1, busy=0 after the 6th write; no 7th trigger.
- Mode 1, mask 4'b0100, depth 2, 8 conversions -> addr sequence 0,1,2,0,1,2,0,1, channel always 2, wrapped=1 from the 4th write onward.
- cfg_abort in the same cycle as the 3rd eoc_rise -> only 2 writes, no further trigger, state IDLE, addr=2.
- btn_start held high 50 cycles plus cfg_start during CONVERT -> exactly one capture started; mask 0 start -> busy stays 0.
- Spurious eoc_rise while IDLE -> adc_write_enable stays 0; async reset mid-capture -> all outputs 0 within the reset assertion.
- (DECIM_EN) cfg_decim=2, depth 3 -> 12 triggers, writes on the 3rd, 6th, 9th and 12th eoc_rise at addr 0..3.

Source files
------------

// File: rtl/adc_multich_recorder.sv
// Round-robin multi-channel ADC capture sequencer producing BRAM write strobes, addresses and channel tags.
// Optional decimation is compiled in with `define ADC_RECORDER_DECIM_EN (adds cfg_decim).
module adc_multich_recorder #(
    parameter int unsigned ADDR_BITS = 16,
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned CH_BITS   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_start,
    input  logic                 btn_start,
    input  logic                 cfg_abort,
    input  logic                 cfg_mode,
    input  logic [NUM_CH-1:0]    cfg_ch_mask,
    input  logic [ADDR_BITS-1:0] cfg_depth,
`ifdef ADC_RECORDER_DECIM_EN
    input  logic [7:0]           cfg_decim,
`endif
    input  logic                 adc_eoc_out,
    output logic                 adc_trigger,
    output logic [CH_BITS-1:0]   adc_channel,
    output logic [ADDR_BITS-1:0] adc_addr,
    output logic                 adc_write_enable,
    output logic                 busy,
    output logic                 done,
    output logic                 wrapped
);
    typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

    state_t              state, state_next;
    logic                btn_d, eoc_d;
    logic                start_evt, eoc_rise;
    logic [NUM_CH-1:0]   mask_q;
    logic                mode_q;
    logic                load, conv_tick, sample_hit;
    logic [CH_BITS-1:0]  first_ch, next_ch;

    function automatic logic [CH_BITS-1:0] lowest_set(input logic [NUM_CH-1:0] m);
        logic [CH_BITS-1:0] ch;
        ch = '0;
        for (int unsigned i = NUM_CH; i > 0; i--) begin
            if (m[CH_BITS'(i - 1)]) ch = CH_BITS'(i - 1);
        end
        return ch;
    endfunction

    // Scanning downward leaves the smallest enabled index above cur; falls back to the lowest set bit.
    function automatic logic [CH_BITS-1:0] following_set(input logic [NUM_CH-1:0] m,
                                                         input logic [CH_BITS-1:0] cur);
        logic [CH_BITS-1:0] ch;
        ch = lowest_set(m);
        for (int unsigned i = NUM_CH; i > 0; i--) begin
            if (m[CH_BITS'(i - 1)] && (CH_BITS'(i - 1) > cur)) ch = CH_BITS'(i - 1);
        end
        return ch;
    endfunction

    assign start_evt = cfg_start | (btn_start & ~btn_d);
    assign eoc_rise  = adc_eoc_out & ~eoc_d;
    assign first_ch  = lowest_set(cfg_ch_mask);
    assign next_ch   = following_set(mask_q, adc_channel);
    assign busy      = (state == CONVERT);

`ifdef ADC_RECORDER_DECIM_EN
    logic [7:0] decim_q, decim_cnt;

    assign sample_hit = (decim_cnt == decim_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            decim_q   <= '0;
            decim_cnt <= '0;
        end else if (load) begin
            decim_q   <= cfg_decim;
            decim_cnt <= '0;
        end else if (conv_tick) begin
            decim_cnt <= sample_hit ? '0 : decim_cnt + 8'd1;
        end
    end
`else
    assign sample_hit = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Abort takes priority over a same-cycle eoc_rise, so the write strobe is never raised with it.
    always_comb begin
        state_next       = state;
        load             = 1'b0;
        conv_tick        = 1'b0;
        adc_write_enable = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start_evt && (cfg_ch_mask != '0)) begin
                    state_next = CONVERT;
                    load       = 1'b1;
                end
            end
            CONVERT: begin
                if (cfg_abort) begin
                    state_next = IDLE;
                end else if (eoc_rise) begin
                    conv_tick        = 1'b1;
                    adc_write_enable = sample_hit;
                    if (sample_hit && (adc_addr == cfg_depth) && !mode_q) state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_d       <= 1'b0;
            eoc_d       <= 1'b0;
            mask_q      <= '0;
            mode_q      <= 1'b0;
            adc_trigger <= 1'b0;
            adc_channel <= '0;
            adc_addr    <= '0;
            done        <= 1'b0;
            wrapped     <= 1'b0;
        end else begin
            btn_d       <= btn_start;
            eoc_d       <= adc_eoc_out;
            adc_trigger <= 1'b0;
            if (load) begin
                mask_q      <= cfg_ch_mask;
                mode_q      <= cfg_mode;
                adc_addr    <= '0;
                adc_channel <= first_ch;
                done        <= 1'b0;
                wrapped     <= 1'b0;
                adc_trigger <= 1'b1;
            end else if (conv_tick) begin
                if (!sample_hit) begin
                    adc_trigger <= 1'b1;
                end else begin
                    adc_channel <= next_ch;
                    if (adc_addr != cfg_depth) begin
                        adc_addr    <= adc_addr + ADDR_BITS'(1);
                        adc_trigger <= 1'b1;
                    end else if (mode_q) begin
                        adc_addr    <= '0;
                        wrapped     <= 1'b1;
                        adc_trigger <= 1'b1;
                    end else begin
                        done <= 1'b1;
                    end
                end
            end
        end
    end
endmodule
